// File: rtl/cpu_prefetch_pkg.sv
// Shared defaults for the duck prefetch unit.
// Bus protocol: a read is presented with bus_read=1 and a stable address; it
// completes in the cycle where bus_read=1 and bus_wait=0, and bus_data_in is
// captured in that same cycle. There is no abort. A reset mid-cycle simply
// drops bus_read, so the slave must tolerate a vanished request.
package cpu_prefetch_pkg;

   localparam int DEF_ADDR_WIDTH = 16;
   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_DEPTH      = 4;
   localparam int DEF_RESET_PC   = 0;

   // Occupancy counters need one extra bit to represent "full".
   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Synchronous FIFO with a registered head entry, flush, and occupancy count.
module prefetch_fifo #(
   parameter int W     = 24,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [W-1:0]             din,
   output logic                     valid,
   output logic [W-1:0]             dout,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [W-1:0]    mem [DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr, rd_next;
   logic [CW-1:0]   cnt_next;
   logic            do_push, do_pop, full;

   // Flush wins over everything; a pop on an empty queue is dropped.
   always_comb begin
      do_push  = push & ~flush;
      do_pop   = pop & valid & ~flush;
      rd_next  = rd_ptr + PW'(do_pop);
      cnt_next = count + CW'(do_push) - CW'(do_pop);
   end

   assign full = (count == CW'(DEPTH));

   // Storage array, deliberately not reset.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointers, count and the registered head; the head forwards din when the
   // new entry lands exactly where the read pointer will point.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         valid  <= 1'b0;
         dout   <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         valid  <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         rd_ptr <= rd_next;
         count  <= cnt_next;
         valid  <= (cnt_next != '0);
         dout   <= (do_push && wr_ptr == rd_next) ? din : mem[rd_next];
      end
   end

   // The request logic reserves a slot before issuing, so overflow is a bug.
   always_ff @(posedge clk) begin
      if (!rst) assert (!(push && !flush && full));
   end

endmodule

// File: rtl/cpu_prefetch.sv
// Instruction prefetch: sequential bus reads into a small queue for decode,
// with redirect (flush + restart) and discard of a stale in-flight read.
module cpu_prefetch
   import cpu_prefetch_pkg::*;
#(
   parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int                    DEPTH      = DEF_DEPTH,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEF_RESET_PC)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      active,
   output logic [ADDR_WIDTH-1:0]     bus_address_out,
   output logic                      bus_read,
   input  logic [DATA_WIDTH-1:0]     bus_data_in,
   input  logic                      bus_wait,
   output logic                      insn_valid,
   output logic [DATA_WIDTH-1:0]     insn_data,
   output logic [ADDR_WIDTH-1:0]     insn_pc,
   input  logic                      insn_ready,
   input  logic                      redirect,
   input  logic [ADDR_WIDTH-1:0]     redirect_pc,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int CW = cnt_width(DEPTH);
   localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [ADDR_WIDTH-1:0] fetch_pc;
   logic                  discard;
   logic                  complete, push, pop, more;
   logic [CW-1:0]         count_next;

   // Handshake decode and room check for keeping the bus busy back-to-back.
   always_comb begin
      complete   = bus_read & ~bus_wait;
      push       = complete & ~discard;
      pop        = insn_valid & insn_ready;
      count_next = count + CW'(push) - CW'(pop);
      more       = ({1'b0, count_next} + (CW+1)'(1)) < DEPTH_W;
   end

   prefetch_fifo #(
      .W     (ADDR_WIDTH + DATA_WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (insn_ready),
      .flush (redirect),
      .din   ({bus_address_out, bus_data_in}),
      .valid (insn_valid),
      .dout  ({insn_pc, insn_data}),
      .count (count)
   );

   // Request / discard control. Redirect first; a stalled read is never
   // aborted, its byte is marked for discard instead.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus_read        <= 1'b0;
         bus_address_out <= '0;
         fetch_pc        <= RESET_PC;
         discard         <= 1'b0;
      end else if (redirect) begin
         if (bus_read && bus_wait) begin
            discard  <= 1'b1;
            fetch_pc <= redirect_pc;
         end else begin
            discard <= 1'b0;
            if (active) begin
               bus_read        <= 1'b1;
               bus_address_out <= redirect_pc;
               fetch_pc        <= redirect_pc + ADDR_WIDTH'(1);
            end else begin
               bus_read <= 1'b0;
               fetch_pc <= redirect_pc;
            end
         end
      end else if (bus_read) begin
         if (!bus_wait) begin
            discard <= 1'b0;
            if (active && more) begin
               bus_address_out <= fetch_pc;
               fetch_pc        <= fetch_pc + ADDR_WIDTH'(1);
            end else begin
               bus_read <= 1'b0;
            end
         end
      end else if (active && count < DEPTH_C) begin
         bus_read        <= 1'b1;
         bus_address_out <= fetch_pc;
         fetch_pc        <= fetch_pc + ADDR_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_cpu_prefetch.sv
// Bench for cpu_prefetch: directed scenarios plus a randomized run checked
// against a queue-based model of the fetched instruction stream.
module tb_cpu_prefetch;

   localparam int AW = 16;
   localparam int DW = 8;
   localparam int DEPTH = 4;

   logic          clk, rst, active, bus_read, bus_wait;
   logic [AW-1:0] bus_address_out, insn_pc, redirect_pc;
   logic [DW-1:0] bus_data_in, insn_data;
   logic          insn_valid, insn_ready, redirect;
   logic [2:0]    count;

   int nvec, nfail;

   cpu_prefetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .RESET_PC('0)) dut (
      .clk(clk), .rst(rst), .active(active),
      .bus_address_out(bus_address_out), .bus_read(bus_read),
      .bus_data_in(bus_data_in), .bus_wait(bus_wait),
      .insn_valid(insn_valid), .insn_data(insn_data), .insn_pc(insn_pc),
      .insn_ready(insn_ready), .redirect(redirect), .redirect_pc(redirect_pc),
      .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory content: low byte + 0x10 + high byte (addr+0x10 below 0x100).
   function automatic logic [7:0] mem_f(input logic [15:0] a);
      return a[7:0] + 8'h10 + a[15:8];
   endfunction

   assign bus_data_in = mem_f(bus_address_out);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; active = 1'b0; insn_ready = 1'b0; redirect = 1'b0;
      redirect_pc = '0; bus_wait = 1'b0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; active = 1'b1; insn_ready = 1'b1; redirect = 1'b0;
      redirect_pc = '0; bus_wait = 1'b0;
      tick();
      nvec++; if (bus_read !== 1'b0) begin nfail++; $display("FAIL reset_bus_read got %b want 0", bus_read); end
      nvec++; if (bus_address_out !== 16'h0) begin nfail++; $display("FAIL reset_addr got %h want 0000", bus_address_out); end
      nvec++; if (insn_valid !== 1'b0) begin nfail++; $display("FAIL reset_valid got %b want 0", insn_valid); end
      nvec++; if (count !== 3'd0) begin nfail++; $display("FAIL reset_count got %0d want 0", count); end
   endtask

   task automatic test_stream();
      do_reset(); active = 1'b1; insn_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         nvec++;
         if (bus_read !== 1'b1 || bus_address_out !== 16'(k)) begin
            nfail++; $display("FAIL stream_addr cyc%0d got %b/%h want 1/%h", k, bus_read, bus_address_out, 16'(k));
         end
         nvec++;
         if (k == 0) begin
            if (insn_valid !== 1'b0) begin nfail++; $display("FAIL stream_first_valid got %b want 0", insn_valid); end
         end else if (insn_valid !== 1'b1 || insn_pc !== 16'(k-1) || insn_data !== mem_f(16'(k-1))) begin
            nfail++; $display("FAIL stream_head cyc%0d got %b/%h/%h want 1/%h/%h", k, insn_valid, insn_pc, insn_data, 16'(k-1), mem_f(16'(k-1)));
         end
      end
   endtask

   task automatic test_fill();
      logic [AW-1:0] addrs[$];
      do_reset(); active = 1'b1; insn_ready = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (bus_read) addrs.push_back(bus_address_out);
      end
      nvec++; if (addrs.size() != 4) begin nfail++; $display("FAIL fill_reads got %0d want 4", addrs.size()); end
      for (int i = 0; i < addrs.size() && i < 4; i++) begin
         nvec++; if (addrs[i] !== 16'(i)) begin nfail++; $display("FAIL fill_addr%0d got %h want %h", i, addrs[i], 16'(i)); end
      end
      nvec++; if (count !== 3'd4 || bus_read !== 1'b0) begin nfail++; $display("FAIL fill_full got %0d/%b want 4/0", count, bus_read); end
      insn_ready = 1'b1; tick(); insn_ready = 1'b0;
      nvec++; if (count !== 3'd3 || insn_pc !== 16'd1) begin nfail++; $display("FAIL fill_pop got %0d/%h want 3/0001", count, insn_pc); end
      addrs.delete();
      for (int k = 0; k < 6; k++) begin
         if (bus_read) addrs.push_back(bus_address_out);
         tick();
      end
      nvec++;
      if (addrs.size() != 1 || addrs[0] !== 16'd4) begin
         nfail++; $display("FAIL fill_refill got %0d reads first %h want 1 read 0004", addrs.size(), (addrs.size() > 0) ? addrs[0] : 16'hxxxx);
      end
      nvec++; if (count !== 3'd4) begin nfail++; $display("FAIL fill_refull got %0d want 4", count); end
   endtask

   task automatic test_stall();
      logic [AW-1:0] popped[$];
      int stall = 0;
      logic pw = 1'b0;
      do_reset(); active = 1'b1; insn_ready = 1'b1;
      for (int k = 0; k < 14; k++) begin
         tick();
         if (pw) begin
            nvec++; if (bus_read !== 1'b1 || bus_address_out !== 16'd2) begin nfail++; $display("FAIL stall_hold got %b/%h want 1/0002", bus_read, bus_address_out); end
         end
         if (insn_valid) begin
            popped.push_back(insn_pc);
            nvec++; if (insn_data !== mem_f(insn_pc)) begin nfail++; $display("FAIL stall_data got %h want %h", insn_data, mem_f(insn_pc)); end
         end
         if (bus_read && bus_address_out == 16'd2 && stall < 3) begin bus_wait = 1'b1; stall++; end
         else bus_wait = 1'b0;
         pw = bus_wait;
      end
      bus_wait = 1'b0;
      nvec++; if (stall != 3 || popped.size() < 5) begin nfail++; $display("FAIL stall_progress got %0d stalls %0d pops want 3 >=5", stall, popped.size()); end
      for (int i = 0; i < popped.size(); i++) begin
         nvec++; if (popped[i] !== 16'(i)) begin nfail++; $display("FAIL stall_seq%0d got %h want %h", i, popped[i], 16'(i)); end
      end
   endtask

   task automatic test_redirect_stalled();
      int guard = 0;
      do_reset(); active = 1'b1; insn_ready = 1'b1;
      tick();
      while (!(bus_read && bus_address_out == 16'd5) && guard < 20) begin tick(); guard++; end
      nvec++; if (guard >= 20) begin nfail++; $display("FAIL redir_reach5 got timeout want addr 0005"); end
      bus_wait = 1'b1; redirect = 1'b1; redirect_pc = 16'h1234;
      tick(); redirect = 1'b0;
      for (int k = 0; k < 2; k++) begin
         nvec++;
         if (count !== 3'd0 || insn_valid !== 1'b0 || bus_read !== 1'b1 || bus_address_out !== 16'd5) begin
            nfail++; $display("FAIL redir_hold%0d got cnt%0d v%b r%b %h want 0/0/1/0005", k, count, insn_valid, bus_read, bus_address_out);
         end
         if (k == 0) tick();
      end
      bus_wait = 1'b0; tick();
      nvec++;
      if (bus_read !== 1'b1 || bus_address_out !== 16'h1234 || count !== 3'd0 || insn_valid !== 1'b0) begin
         nfail++; $display("FAIL redir_newreq got r%b %h cnt%0d v%b want 1 1234 0 0", bus_read, bus_address_out, count, insn_valid);
      end
      tick();
      nvec++;
      if (insn_valid !== 1'b1 || insn_pc !== 16'h1234 || insn_data !== 8'h56) begin
         nfail++; $display("FAIL redir_head got %b/%h/%h want 1/1234/56", insn_valid, insn_pc, insn_data);
      end
   endtask

   task automatic test_redirect_push_pop();
      int n = 0;
      do_reset(); active = 1'b1; insn_ready = 1'b1;
      tick(); tick(); tick();
      redirect = 1'b1; redirect_pc = 16'h0300;
      tick(); redirect = 1'b0;
      nvec++; if (insn_valid !== 1'b0 || count !== 3'd0) begin nfail++; $display("FAIL rpp_flush got v%b cnt%0d want 0/0", insn_valid, count); end
      nvec++; if (bus_read !== 1'b1 || bus_address_out !== 16'h0300) begin nfail++; $display("FAIL rpp_req got %b/%h want 1/0300", bus_read, bus_address_out); end
      for (int k = 0; k < 6; k++) begin
         tick();
         if (insn_valid) begin
            nvec++; if (insn_pc !== 16'h0300 + 16'(n)) begin nfail++; $display("FAIL rpp_seq got %h want %h", insn_pc, 16'h0300 + 16'(n)); end
            n++;
         end
      end
      nvec++; if (n < 5) begin nfail++; $display("FAIL rpp_count got %0d want >=5", n); end
   endtask

   task automatic test_wrap();
      logic [AW-1:0] exp_a [4];
      exp_a[0] = 16'hFFFE; exp_a[1] = 16'hFFFF; exp_a[2] = 16'h0000; exp_a[3] = 16'h0001;
      do_reset(); active = 1'b1; insn_ready = 1'b1;
      tick(); tick();
      redirect = 1'b1; redirect_pc = 16'hFFFE;
      tick(); redirect = 1'b0;
      for (int i = 0; i < 4; i++) begin
         nvec++;
         if (bus_read !== 1'b1 || bus_address_out !== exp_a[i]) begin
            nfail++; $display("FAIL wrap_addr%0d got %b/%h want 1/%h", i, bus_read, bus_address_out, exp_a[i]);
         end
         tick();
      end
   endtask

   task automatic test_rst_midstall();
      do_reset(); active = 1'b1; insn_ready = 1'b1;
      tick(); tick(); tick();
      bus_wait = 1'b1; tick(); tick();
      #2 rst = 1'b1; #1;
      nvec++; if (bus_read !== 1'b0 || count !== 3'd0 || insn_valid !== 1'b0) begin
         nfail++; $display("FAIL rst_async got r%b cnt%0d v%b want 0/0/0", bus_read, count, insn_valid);
      end
      bus_wait = 1'b0; tick(); rst = 1'b0;
      tick();
      nvec++; if (bus_read !== 1'b1 || bus_address_out !== 16'h0000) begin nfail++; $display("FAIL rst_restart got %b/%h want 1/0000", bus_read, bus_address_out); end
   endtask

   task automatic test_random();
      logic [AW-1:0] q[$];
      logic [AW-1:0] exp_addr = '0;
      logic drop = 1'b0;
      logic p_read = 1'b0, p_wait = 1'b0, p_active = 1'b0, have_prev = 1'b0;
      logic [AW-1:0] p_addr = '0;
      int guard = 0;
      do_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         nvec++; if (count !== 3'(q.size())) begin nfail++; $display("FAIL rnd_count cyc%0d got %0d want %0d", cyc, count, q.size()); end
         nvec++; if (insn_valid !== (q.size() != 0)) begin nfail++; $display("FAIL rnd_valid cyc%0d got %b want %b", cyc, insn_valid, q.size() != 0); end
         if (q.size() != 0) begin
            nvec++; if (insn_pc !== q[0] || insn_data !== mem_f(q[0])) begin nfail++; $display("FAIL rnd_head cyc%0d got %h/%h want %h/%h", cyc, insn_pc, insn_data, q[0], mem_f(q[0])); end
         end
         if (have_prev && p_read && p_wait) begin
            nvec++; if (bus_read !== 1'b1 || bus_address_out !== p_addr) begin nfail++; $display("FAIL rnd_hold cyc%0d got %b/%h want 1/%h", cyc, bus_read, bus_address_out, p_addr); end
         end
         if (have_prev && bus_read && !(p_read && p_wait)) begin
            nvec++; if (!p_active) begin nfail++; $display("FAIL rnd_issue_inactive cyc%0d got issue want none", cyc); end
         end
         active      = ($urandom % 8) != 0;
         insn_ready  = ((cyc / 200) % 2 == 1) ? (($urandom % 4) != 0) : (($urandom % 4) == 0);
         bus_wait    = ($urandom % 3) == 0;
         redirect    = ($urandom % 20) == 0;
         redirect_pc = (($urandom % 4) == 0) ? (16'hFFFC + 16'($urandom % 4)) : 16'($urandom);
         if (redirect) begin
            q.delete();
            drop = bus_read && bus_wait;
            exp_addr = redirect_pc;
         end else begin
            if (insn_ready && q.size() != 0) void'(q.pop_front());
            if (bus_read && !bus_wait) begin
               if (drop) drop = 1'b0;
               else begin
                  nvec++; if (bus_address_out !== exp_addr) begin nfail++; $display("FAIL rnd_addr cyc%0d got %h want %h", cyc, bus_address_out, exp_addr); end
                  q.push_back(exp_addr);
                  exp_addr = exp_addr + 16'd1;
               end
            end
         end
         p_read = bus_read; p_wait = bus_wait; p_active = active; p_addr = bus_address_out; have_prev = 1'b1;
         tick();
      end
      redirect = 1'b0; active = 1'b1; insn_ready = 1'b1; bus_wait = 1'b0;
      while (!insn_valid && guard < 10) begin tick(); guard++; end
      nvec++; if (!insn_valid) begin nfail++; $display("FAIL rnd_live got no valid want valid within 10 cycles"); end
   endtask

   initial begin
      nvec = 0; nfail = 0;
      test_reset();
      test_stream();
      test_fill();
      test_stall();
      test_redirect_stalled();
      test_redirect_push_pop();
      test_wrap();
      test_rst_midstall();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
